// File: rtl/gx4000_dma_sequencer.sv
// Plus-ASIC sound DMA sequencer: scans the three DMA channels on each scanline,
// fetches/executes one instruction per active channel over a shared RAM read
// port and issues single-register PSG writes.
module gx4000_dma_sequencer #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       plus_mode,
  input  logic                       hsync_tick,
  input  logic [NUM_CH-1:0]          dma_en,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_in,
  input  logic [NUM_CH-1:0]          ch_addr_load,
  input  logic [NUM_CH*8-1:0]        ch_prescale,
  input  logic [NUM_CH-1:0]          irq_clear,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic [15:0]                mem_data,
  output logic                       psg_wr,
  output logic [3:0]                 psg_reg,
  output logic [7:0]                 psg_data,
  input  logic                       psg_busy,
  output logic [NUM_CH*ADDR_W-1:0]   ch_addr_out,
  output logic [NUM_CH-1:0]          ch_active,
  output logic [NUM_CH-1:0]          irq_status,
  output logic                       overrun
);

  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // 12-bit count times (prescaler + 1) fits in 21 bits
  localparam int unsigned PauseW = 21;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StFetch,
    StExec,
    StPsg,
    StNext
  } state_e;

  state_e             state_q, state_d;
  logic [ChW-1:0]     ch_q, ch_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic [15:0]        word_q, word_d;
  logic [3:0]         psg_reg_q, psg_reg_d;
  logic [7:0]         psg_data_q, psg_data_d;

  logic [ADDR_W-1:0]  addr_q      [NUM_CH];
  logic [ADDR_W-1:0]  addr_d      [NUM_CH];
  logic [PauseW-1:0]  pause_q     [NUM_CH];
  logic [PauseW-1:0]  pause_d     [NUM_CH];
  logic [11:0]        loop_cnt_q  [NUM_CH];
  logic [11:0]        loop_cnt_d  [NUM_CH];
  logic [ADDR_W-1:0]  loop_addr_q [NUM_CH];
  logic [ADDR_W-1:0]  loop_addr_d [NUM_CH];
  logic [NUM_CH-1:0]  active_q, active_d;
  logic [NUM_CH-1:0]  irq_q, irq_d;

  logic [7:0]         presc    [NUM_CH];
  logic [ADDR_W-1:0]  addr_in  [NUM_CH];

  // Unpack per-channel slices of the register-file buses
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      presc[i]   = ch_prescale[i*8 +: 8];
      addr_in[i] = ch_addr_in[i*ADDR_W +: ADDR_W] & ~ADDR_W'(1);
    end
  end

  // Sequencer next state plus per-channel state updates
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pending_d   = pending_q;
    overrun_d   = 1'b0;
    word_d      = word_q;
    psg_reg_d   = psg_reg_q;
    psg_data_d  = psg_data_q;
    addr_d      = addr_q;
    pause_d     = pause_q;
    loop_cnt_d  = loop_cnt_q;
    loop_addr_d = loop_addr_q;
    active_d    = active_q;
    // Clear first so an INT executed this cycle wins over irq_clear
    irq_d       = irq_q & ~irq_clear;

    // A tick arriving mid-sequence is queued once; a second one is dropped
    if (!plus_mode) begin
      pending_d = 1'b0;
    end else if (hsync_tick && (state_q != StIdle)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (plus_mode && (hsync_tick || pending_q)) begin
          state_d   = StScan;
          ch_d      = '0;
          // Tick and queued tick together: serve one, keep one queued
          pending_d = hsync_tick & pending_q;
        end
      end
      StScan: begin
        if (!plus_mode) begin
          state_d = StIdle;
        end else if (dma_en[ch_q] && active_q[ch_q]) begin
          if (pause_q[ch_q] != '0) begin
            pause_d[ch_q] = pause_q[ch_q] - PauseW'(1);
            state_d       = StNext;
          end else begin
            state_d = StFetch;
          end
        end else begin
          state_d = StNext;
        end
      end
      StFetch: begin
        if (mem_ack) begin
          if (ch_addr_load[ch_q]) begin
            // Register-file reload wins; the fetched word is discarded
            state_d = StNext;
          end else begin
            word_d        = mem_data;
            addr_d[ch_q]  = addr_q[ch_q] + ADDR_W'(2);
            state_d       = StExec;
          end
        end
      end
      StExec: begin
        state_d = StNext;
        case (word_q[15:12])
          4'h0: begin
            psg_reg_d  = word_q[11:8];
            psg_data_d = word_q[7:0];
            state_d    = StPsg;
          end
          4'h1: begin
            if (word_q[11:0] != 12'd0) begin
              pause_d[ch_q] = PauseW'(word_q[11:0]) * (PauseW'(presc[ch_q]) + PauseW'(1));
            end
          end
          4'h2: begin
            loop_cnt_d[ch_q]  = word_q[11:0];
            loop_addr_d[ch_q] = addr_q[ch_q];
          end
          4'h4: begin
            if (word_q[0] && (loop_cnt_q[ch_q] != 12'd0)) begin
              loop_cnt_d[ch_q] = loop_cnt_q[ch_q] - 12'd1;
              addr_d[ch_q]     = loop_addr_q[ch_q];
            end
            if (word_q[4]) irq_d[ch_q]    = 1'b1;
            if (word_q[5]) active_d[ch_q] = 1'b0;
          end
          default: ;
        endcase
      end
      StPsg: begin
        if (!psg_busy) state_d = StNext;
      end
      StNext: begin
        if (plus_mode && (ch_q != ChW'(NUM_CH - 1))) begin
          ch_d    = ch_q + ChW'(1);
          state_d = StScan;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Address reloads override anything the sequencer did to that channel
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch_addr_load[i]) begin
        addr_d[i]      = addr_in[i];
        pause_d[i]     = '0;
        loop_cnt_d[i]  = '0;
        loop_addr_d[i] = '0;
        active_d[i]    = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      word_q     <= '0;
      psg_reg_q  <= '0;
      psg_data_q <= '0;
      active_q   <= '0;
      irq_q      <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        addr_q[i]      <= '0;
        pause_q[i]     <= '0;
        loop_cnt_q[i]  <= '0;
        loop_addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      word_q      <= word_d;
      psg_reg_q   <= psg_reg_d;
      psg_data_q  <= psg_data_d;
      active_q    <= active_d;
      irq_q       <= irq_d;
      addr_q      <= addr_d;
      pause_q     <= pause_d;
      loop_cnt_q  <= loop_cnt_d;
      loop_addr_q <= loop_addr_d;
    end
  end

  // Output decode; bus strobes follow the state register only
  always_comb begin
    mem_req  = (state_q == StFetch);
    mem_addr = mem_req ? addr_q[ch_q] : '0;
    psg_wr   = (state_q == StPsg);
    ch_addr_out = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_addr_out[i*ADDR_W +: ADDR_W] = addr_q[i];
    end
  end

  assign psg_reg    = psg_reg_q;
  assign psg_data   = psg_data_q;
  assign ch_active  = active_q;
  assign irq_status = irq_q;
  assign overrun    = overrun_q;

endmodule
